// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes, data-memory
// miss freezes and the ecall-halt drain sequence, plus a lost-cycle counter.
module hazard_control_unit #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_mem_read,
    input  logic        EX_mispredict,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        EX_MEM_is_halt,
    output logic        pc_write,
    output logic        IF_ID_write,
    output logic        ID_EX_bubble,
    output logic        IF_ID_flush,
    output logic        freeze,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] drain_cnt_r;
    logic [CNT_W-1:0] drain_cnt_nxt_s;
    logic             halted_r;
    logic [15:0]      stall_count_r;

    logic             active_s;
    logic             miss_s;
    logic             rs1_hit_s;
    logic             rs2_hit_s;
    logic             load_use_s;
    logic             pc_write_s;
    logic             if_id_write_s;
    logic             id_ex_bubble_s;
    logic             if_id_flush_s;
    logic             freeze_s;

    // Hazard detection terms shared by the next-state/strobe logic.
    always_comb begin
        active_s   = 1'b0;
        miss_s     = 1'b0;
        rs1_hit_s  = 1'b0;
        rs2_hit_s  = 1'b0;
        load_use_s = 1'b0;
        if ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        miss_s     = active_s & dmem_req & ~dmem_ready;
        rs1_hit_s  = ID_use_rs1 & (ID_rs1 == ID_EX_rd);
        rs2_hit_s  = ID_use_rs2 & (ID_rs2 == ID_EX_rd);
        load_use_s = ID_EX_mem_read & (ID_EX_rd != 5'd0) & (rs1_hit_s | rs2_hit_s);
    end

    // Next-state and strobe decode; the unfrozen MEM_WAIT exit cycle behaves as
    // RUN so that a mispredict or halt held during the miss is still acted on.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        pc_write_s      = 1'b1;
        if_id_write_s   = 1'b1;
        id_ex_bubble_s  = 1'b0;
        if_id_flush_s   = 1'b0;
        freeze_s        = 1'b0;
        case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
                if (miss_s) begin
                    freeze_s      = 1'b1;
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    state_nxt_s   = ST_MEM_WAIT;
                end else if (EX_mispredict) begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    state_nxt_s    = ST_RUN;
                end else if (load_use_s) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_bubble_s = 1'b1;
                    state_nxt_s    = ST_RUN;
                end else if (EX_MEM_is_halt) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = DRAIN_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_bubble_s = 1'b1;
                if (drain_cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HALT: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_bubble_s = 1'b1;
            end
            default: begin
                state_nxt_s     = ST_RUN;
                drain_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, drain counter and halt flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= {CNT_W{1'b0}};
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            halted_r    <= (state_r == ST_HALT);
        end
    end

    // Saturating count of cycles lost to stalls and freezes while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= 16'd0;
        end else if (active_s && !pc_write_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign pc_write     = pc_write_s;
    assign IF_ID_write  = if_id_write_s;
    assign ID_EX_bubble = id_ex_bubble_s;
    assign IF_ID_flush  = if_id_flush_s;
    assign freeze       = freeze_s;
    assign halted       = halted_r;
    assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising edge.
module tb_hazard_control_unit;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic        ID_use_rs1;
    logic        ID_use_rs2;
    logic [4:0]  ID_EX_rd;
    logic        ID_EX_mem_read;
    logic        EX_mispredict;
    logic        dmem_req;
    logic        dmem_ready;
    logic        EX_MEM_is_halt;
    logic        pc_write;
    logic        IF_ID_write;
    logic        ID_EX_bubble;
    logic        IF_ID_flush;
    logic        freeze;
    logic        halted;
    logic [15:0] stall_count;

    int chk_cnt;
    int pass_cnt;

    hazard_control_unit #(.DRAIN_CYCLES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_use_rs1     (ID_use_rs1),
        .ID_use_rs2     (ID_use_rs2),
        .ID_EX_rd       (ID_EX_rd),
        .ID_EX_mem_read (ID_EX_mem_read),
        .EX_mispredict  (EX_mispredict),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .EX_MEM_is_halt (EX_MEM_is_halt),
        .pc_write       (pc_write),
        .IF_ID_write    (IF_ID_write),
        .ID_EX_bubble   (ID_EX_bubble),
        .IF_ID_flush    (IF_ID_flush),
        .freeze         (freeze),
        .halted         (halted),
        .stall_count    (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt = chk_cnt + 1;
        if (got === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, freeze}
    task automatic check_strobes(input string tag, input logic [4:0] exp);
        check_eq(tag, {11'd0, pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, freeze},
                 {11'd0, exp});
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic mr,
                         input logic mp, input logic req, input logic rdy, input logic hlt);
        ID_rs1         = rs1;
        ID_rs2         = rs2;
        ID_use_rs1     = u1;
        ID_use_rs2     = u2;
        ID_EX_rd       = rd;
        ID_EX_mem_read = mr;
        EX_mispredict  = mp;
        dmem_req       = req;
        dmem_ready     = rdy;
        EX_MEM_is_halt = hlt;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to the next falling edge; caller drives, then waits 1 ns to sample.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    localparam logic [4:0] S_RUN   = 5'b11000;
    localparam logic [4:0] S_LU    = 5'b00100;
    localparam logic [4:0] S_MP    = 5'b11110;
    localparam logic [4:0] S_FRZ   = 5'b00001;
    localparam logic [4:0] S_DRAIN = 5'b00100;

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        reset_n  = 1'b0;
        idle();
        #2;
        check_strobes("reset_strobes", S_RUN);
        check_eq("reset_halted", {15'd0, halted}, 16'd0);
        check_eq("reset_stall_count", stall_count, 16'd0);

        next_cycle();
        reset_n = 1'b1;
        #1;
        check_strobes("idle_run", S_RUN);

        // load-use on rs2
        next_cycle();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_rs2_stall", S_LU);
        next_cycle();
        idle();
        #1;
        check_strobes("lu_rs2_one_cycle", S_RUN);
        check_eq("lu_rs2_count", stall_count, 16'd1);

        // load-use on rs1
        next_cycle();
        drive(5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_rs1_stall", S_LU);

        // no-stall variants: rd=x0, rs2 unused, not a load, rs1 unused
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_rd_zero", S_RUN);
        check_eq("lu_rs1_count", stall_count, 16'd2);
        next_cycle();
        drive(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_rs2_unused", S_RUN);
        next_cycle();
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_not_load", S_RUN);
        next_cycle();
        drive(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("lu_rs1_unused", S_RUN);

        // mispredict beats load-use
        next_cycle();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("mp_over_lu", S_MP);
        next_cycle();
        idle();
        #1;
        check_eq("mp_count_same", stall_count, 16'd2);

        // three-cycle miss then ready
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            check_strobes($sformatf("miss_freeze_%0d", i), S_FRZ);
        end
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check_strobes("miss_ready", S_RUN);
        check_eq("miss_count", stall_count, 16'd5);
        next_cycle();
        idle();
        #1;
        check_strobes("miss_back_run", S_RUN);
        check_eq("miss_count_hold", stall_count, 16'd5);

        // miss and mispredict together: freeze first, flush on the ready cycle
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_strobes("miss_mp_freeze", S_FRZ);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_strobes("miss_mp_flush", S_MP);
        check_eq("miss_mp_count", stall_count, 16'd6);

        // halt at cycle t
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check_strobes("halt_entry", S_RUN);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_strobes("drain_t1", S_DRAIN);
        check_eq("drain_t1_halted", {15'd0, halted}, 16'd0);
        next_cycle();
        idle();
        #1;
        check_strobes("drain_t2", S_DRAIN);
        check_eq("drain_t2_halted", {15'd0, halted}, 16'd0);
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_strobes("halt_t3", S_DRAIN);
        check_eq("halt_t3_halted", {15'd0, halted}, 16'd0);
        next_cycle();
        idle();
        #1;
        check_eq("halt_t4_halted", {15'd0, halted}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            check_strobes($sformatf("halt_hold_%0d", i), S_DRAIN);
        end
        check_eq("halt_count_same", stall_count, 16'd6);

        // asynchronous reset in HALT
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("halt_reset_halted", {15'd0, halted}, 16'd0);
        check_eq("halt_reset_count", stall_count, 16'd0);
        check_strobes("halt_reset_strobes", S_RUN);
        next_cycle();
        reset_n = 1'b1;

        // reset in the middle of MEM_WAIT
        next_cycle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_strobes("mw_freeze_0", S_FRZ);
        next_cycle();
        #1;
        check_strobes("mw_freeze_1", S_FRZ);
        check_eq("mw_count", stall_count, 16'd1);
        #1;
        reset_n  = 1'b0;
        dmem_req = 1'b0;
        #1;
        check_eq("mw_reset_freeze", {15'd0, freeze}, 16'd0);
        check_eq("mw_reset_count", stall_count, 16'd0);
        check_eq("mw_reset_halted", {15'd0, halted}, 16'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        idle();
        #1;
        check_strobes("mw_after_release", S_RUN);
        check_eq("mw_after_count", stall_count, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
